bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using the double-dabble algorithm, one
// bit per clock. Optional two's-complement input with the sign reported apart.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  // Saturates well above 2^32 so large DIGITS values cannot overflow.
  function automatic longint unsigned pow10_sat(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      if (r < (64'd1 << 40)) r = r * 64'd10;
    end
    return r;
  endfunction

  localparam longint unsigned MAX_MAG = (SIGNED != 0) ? (64'd1 << (WIDTH - 1))
                                                      : ((64'd1 << WIDTH) - 64'd1);

  generate
    if (WIDTH < 4 || WIDTH > 32 || DIGITS < 1 || pow10_sat(DIGITS) <= MAX_MAG) begin : g_bad_cfg
      $error("bin2bcd_seq: DIGITS too small for WIDTH/SIGNED, or WIDTH out of 4..32");
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               sign_q, sign_d;
  logic               sign_pend_q, sign_pend_d;

  logic               is_neg;
  logic [WIDTH:0]     neg_ext;
  logic [WIDTH-1:0]   mag;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   step_scratch;
  logic [WIDTH-1:0]   step_shift;

  // Negation is one bit wider so the most-negative input yields 2^(WIDTH-1).
  always_comb begin
    is_neg  = (SIGNED != 0) && bin_in[WIDTH-1];
    neg_ext = -{bin_in[WIDTH-1], bin_in};
    mag     = is_neg ? WIDTH'(neg_ext) : bin_in;
  end

  // One double-dabble step: correct digits >= 5, then shift the pair left.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                    : scratch_q[4*i +: 4];
    end
    step_scratch = BCD_W'({adj, shift_q[WIDTH-1]});
    step_shift   = {shift_q[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    // NOTE: every target gets a default first so no path infers a latch.
    state_d     = state_q;
    shift_d     = shift_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    sign_pend_d = sign_pend_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shift_d     = mag;
          scratch_d   = '0;
          cnt_d       = CNT_W'(WIDTH);
          busy_d      = 1'b1;
          sign_pend_d = is_neg;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = step_shift;
        scratch_d = step_scratch;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = step_scratch;
          sign_d  = sign_pend_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use <= so every flop samples pre-edge values together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bcd_q       <= '0;
      sign_q      <= 1'b0;
      sign_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bcd_q       <= bcd_d;
      sign_q      <= sign_d;
      sign_pend_q <= sign_pend_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_q;
  assign sign_out = sign_q;

endmodule
